// File: rtl/sd_dma_ram_writer.sv
// ---------------------------------------------------------------------------
// sd_dma_ram_writer
//
// Bridges the SD DMA engine's byte-write interface to the SRAM arbiter.
// Each falling edge of the engine's active-low write strobe captures one
// byte. The byte is tagged with the current capture address and queued in a
// small FIFO. A two-state drain FSM empties the FIFO over a req/ack
// handshake. The FIFO absorbs arbiter latency against the fixed SD cadence.
//
// Optional feature: define SD_DMA_RAM_WRITER_CKSUM_EN to enable the 16-bit
// running byte sum on CKSUM. When it is undefined, CKSUM is tied to zero.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   DMA_START          pulse: load DMA_BASE_ADDR, clear count/flags (if idle)
//   DMA_BASE_ADDR      address of the first byte of a transfer
//   SD_DMA_STATUS      high while the SD engine is transferring
//   SD_DMA_SRAM_WE     active-low byte strobe; falling edge captures a byte
//   SD_DMA_NEXTADDR    pulse: advance the capture address
//   SD_DMA_SRAM_DATA   byte data, valid while the strobe is low
//   RAM_REQ/ADDR/DATA  write request to the arbiter, held until RAM_ACK
//   RAM_ACK            one-cycle acknowledge from the arbiter
//   BYTE_COUNT         bytes captured since DMA_START, saturating
//   OVERFLOW           sticky: a byte was dropped on a full FIFO
//   BUSY, DONE         activity flag and its one-cycle falling-edge pulse
//   CKSUM              running byte sum (optional feature)
// ---------------------------------------------------------------------------
module sd_dma_ram_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DMA_START,
  input  logic [ADDR_W-1:0] DMA_BASE_ADDR,
  input  logic              SD_DMA_STATUS,
  input  logic              SD_DMA_SRAM_WE,
  input  logic              SD_DMA_NEXTADDR,
  input  logic [7:0]        SD_DMA_SRAM_DATA,
  output logic              RAM_REQ,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [7:0]        RAM_DATA,
  input  logic              RAM_ACK,
  output logic [15:0]       BYTE_COUNT,
  output logic              OVERFLOW,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       CKSUM
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_data_q;
  logic [15:0]       byte_cnt_q;
  logic              ovf_q;
  logic              we_prev_q;
  logic              busy_q;
  state_e            state_q, state_d;

  logic empty, full, busy, start_acc, capture, push_req, push, pop;
  logic load_head, load_next;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH);
  assign busy      = SD_DMA_STATUS | ~empty | (state_q == S_REQ);
  assign start_acc = DMA_START & ~busy;
  // The strobe register resets high, so a strobe already low out of reset
  // is not mistaken for a capture.
  assign capture   = we_prev_q & ~SD_DMA_SRAM_WE;
  // An accepted DMA_START takes priority, and the coincident byte is ignored.
  assign push_req  = capture & ~start_acc;
  // A pop at the same edge frees a slot, so a full FIFO can still accept.
  assign push      = push_req & (~full | pop);
  assign rd_next   = rd_ptr_q + PTR_W'(1);

  // Drain FSM: next state and handshake strobes.
  // NOTE: every always_comb output gets a default first; otherwise a path that
  // leaves a signal unassigned infers a latch.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_next = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          load_head = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (RAM_ACK) begin
          pop = 1'b1;
          // Only entries already stored count here. A byte pushed in this
          // same cycle is not yet readable, so IDLE picks it up next cycle.
          if (count_q > CNT_W'(1)) load_next = 1'b1;
          else                     state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: cap_addr_q, data: SD_DMA_SRAM_DATA};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cap_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
      we_prev_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_prev_q <= SD_DMA_SRAM_WE;
      busy_q    <= busy;

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_next;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (load_head) begin
        ram_addr_q <= mem_q[rd_ptr_q].addr;
        ram_data_q <= mem_q[rd_ptr_q].data;
      end else if (load_next) begin
        ram_addr_q <= mem_q[rd_next].addr;
        ram_data_q <= mem_q[rd_next].data;
      end

      // Capture happens before the increment, so a coincident
      // NEXTADDR leaves the pushed entry with the old address.
      if (start_acc)            cap_addr_q <= DMA_BASE_ADDR;
      else if (SD_DMA_NEXTADDR) cap_addr_q <= cap_addr_q + ADDR_W'(1);

      if (start_acc) begin
        byte_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else if (push_req) begin
        if (byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
        if (full && !pop)           ovf_q      <= 1'b1;
      end
    end
  end

`ifdef SD_DMA_RAM_WRITER_CKSUM_EN
  logic [15:0] cksum_q;

  // Dropped bytes are still summed. This sum covers what the SD engine
  // delivered, not only what reached memory.
  always_ff @(posedge CLK) begin
    if (RST)           cksum_q <= '0;
    else if (start_acc) cksum_q <= '0;
    else if (push_req)  cksum_q <= cksum_q + {8'h00, SD_DMA_SRAM_DATA};
  end

  assign CKSUM = cksum_q;
`else
  assign CKSUM = 16'h0000;
`endif

  assign RAM_REQ    = (state_q == S_REQ);
  assign RAM_ADDR   = ram_addr_q;
  assign RAM_DATA   = ram_data_q;
  assign BYTE_COUNT = byte_cnt_q;
  assign OVERFLOW   = ovf_q;
  assign BUSY       = busy;
  // busy_q is cleared by reset, so a reset that kills activity gives no DONE.
  assign DONE       = busy_q & ~busy;

endmodule

// File: doc/sd_dma_ram_writer.md
Name: sd_dma_ram_writer

Overview:
- Sits directly downstream of the SD DMA engine.
- Consumes the engine's active-low byte-write strobe, next-address pulse and byte data, and attaches a 24-bit target address to each byte.
- Buffers address/data pairs in a small FIFO and drains them to the SRAM arbiter over a req/ack handshake.
- This decouples the fixed SD byte cadence (one byte per 8 CLK) from variable memory-arbiter latency.

Parameters:
- FIFO_DEPTH, 8, number of {addr,data} entries; power of two, minimum 2.
- ADDR_W, 24, SRAM address width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- DMA_START  in  1  one-cycle pulse: load base address, clear counters and flags.
- DMA_BASE_ADDR  in  ADDR_W  address of first byte, sampled on DMA_START.
- SD_DMA_STATUS  in  1  high while the SD DMA engine is transferring.
- SD_DMA_SRAM_WE  in  1  active-low byte-write strobe from the SD DMA engine.
- SD_DMA_NEXTADDR  in  1  one-cycle-high pulse: advance capture address.
- SD_DMA_SRAM_DATA  in  8  byte data, valid while SD_DMA_SRAM_WE is low.
- RAM_REQ  out  1  write request to the SRAM arbiter.
- RAM_ADDR  out  ADDR_W  write address, stable while RAM_REQ is high.
- RAM_DATA  out  8  write data, stable while RAM_REQ is high.
- RAM_ACK  in  1  one-cycle acknowledge from the arbiter.
- BYTE_COUNT  out  16  bytes captured since DMA_START; saturates at 16'hFFFF.
- OVERFLOW  out  1  sticky: a byte was dropped because the FIFO was full.
- BUSY  out  1  transfer or drain in progress.
- DONE  out  1  one-cycle pulse when the transfer has fully drained.
- CKSUM  out  16  running byte sum (see Optional Feature).

Behaviour:
- Reset (RST=1 at posedge CLK):
  - FIFO empty; capture address 0; FSM in IDLE.
  - RAM_REQ=0, RAM_ADDR=0, RAM_DATA=0.
  - BYTE_COUNT=0, OVERFLOW=0, BUSY=0, DONE=0, CKSUM=0.
  - Reset mid-request abandons the request; the arbiter must tolerate RAM_REQ dropping.
- Inputs are used directly; they are synchronous to CLK.
- Capture:
  - SD_DMA_SRAM_WE is registered one cycle; a falling edge (prev=1, now=0) is a capture event.
  - On a capture event, push {capture address, SD_DMA_SRAM_DATA} and increment BYTE_COUNT (saturating).
  - A low strobe held for several cycles produces exactly one push.
- Address: an SD_DMA_NEXTADDR high cycle increments the capture address modulo 2^ADDR_W; 24'hFFFFFF wraps to 0.
- Simultaneous capture event and NEXTADDR in the same cycle: push uses the pre-increment address.
- FIFO:
  - Push when full with no pop in the same cycle: byte dropped, OVERFLOW set, BYTE_COUNT still increments.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
- Drain FSM:
  - IDLE: if FIFO is non-empty, load RAM_ADDR/RAM_DATA from the head and go to REQ; RAM_REQ rises the next cycle.
  - REQ: RAM_REQ=1; RAM_ADDR/RAM_DATA held stable.
  - REQ on RAM_ACK=1: pop head. If more entries remain, reload the next head and stay in REQ with RAM_REQ kept high (back-to-back). Otherwise go to IDLE and drop RAM_REQ.
  - Minimum latency from capture event to RAM_REQ high: 2 cycles.
- BUSY = SD_DMA_STATUS | FIFO non-empty | (state==REQ).
- DONE: one-cycle pulse on the cycle BUSY falls from 1 to 0.
- DMA_START:
  - Accepted only when BUSY=0; ignored otherwise (no state change).
  - When accepted: capture address <= DMA_BASE_ADDR; BYTE_COUNT, OVERFLOW and CKSUM cleared.
  - DMA_START and a capture event in the same cycle: DMA_START wins; the byte is not pushed.
- OVERFLOW and BYTE_COUNT persist after DONE until the next accepted DMA_START or RST.

Optional Feature:
- Macro SD_DMA_RAM_WRITER_CKSUM_EN.
- Defined: CKSUM accumulates the 16-bit modulo sum of every captured byte, including dropped ones. It is cleared by RST and by an accepted DMA_START, and updated on the cycle after the capture event. Firmware uses it to verify a sector independently of SD CRC.
- Undefined: the adder is removed and CKSUM is tied to 16'h0000.

Test Plan:
- RST, then DMA_START with base 24'h0F0000; drive 4 bytes 0x11,0x22,0x33,0x44 at SD cadence (WE low 5 cycles, NEXTADDR after each) with RAM_ACK returned 1 cycle after RAM_REQ -> writes to 0F0000..0F0003 with matching data; BYTE_COUNT=4; DONE pulses once after SD_DMA_STATUS falls; CKSUM=0x00AA (0 without macro).
- Base 24'hFFFFFE, 3 bytes -> RAM_ADDR sequence FFFFFE, FFFFFF, 000000.
- RAM_ACK held low for 100 cycles while 12 bytes arrive, FIFO_DEPTH=8 -> OVERFLOW=1, BYTE_COUNT=12, exactly 8 writes issued once ACK resumes, with addresses base+0..base+7.
- RAM_ACK tied high continuously -> RAM_REQ stays high back-to-back while the FIFO is non-empty; no entry written twice.
- DMA_START pulsed while BUSY=1 -> ignored: capture address and BYTE_COUNT unchanged, no flush.
- RST asserted while RAM_REQ=1 with 3 entries queued -> next cycle RAM_REQ=0, BUSY=0, FIFO empty, no DONE pulse.
